// File: rtl/video_timing_pkg.sv
// Shared raster definitions: standard mode tuples, region encoding and axis length helper.
package video_timing_pkg;

   typedef enum logic [1:0] {
      ACTIVE      = 2'd0,
      FRONT_PORCH = 2'd1,
      SYNC        = 2'd2,
      BACK_PORCH  = 2'd3
   } region_e;

   typedef struct packed {
      int unsigned h_active;
      int unsigned h_fp;
      int unsigned h_sync;
      int unsigned h_bp;
      int unsigned v_active;
      int unsigned v_fp;
      int unsigned v_sync;
      int unsigned v_bp;
   } mode_t;

   localparam mode_t MODE_1080P60 = '{1920, 88, 44, 148, 1080, 4, 5, 36};
   localparam mode_t MODE_720P60  = '{1280, 110, 40, 220, 720, 5, 5, 20};
   localparam mode_t MODE_480P60  = '{640, 16, 96, 48, 480, 10, 2, 33};

   function automatic int unsigned axis_total(input int unsigned active_len,
                                              input int unsigned fp_len,
                                              input int unsigned sync_len,
                                              input int unsigned bp_len);
      return active_len + fp_len + sync_len + bp_len;
   endfunction

endpackage

// File: rtl/timing_axis_counter.sv
// One raster axis: wrapping position counter with wrap strobe and region decode.
module timing_axis_counter
   import video_timing_pkg::*;
#(
   parameter int unsigned BUS_WIDTH  = 12,
   parameter int unsigned ACTIVE_LEN = 1920,
   parameter int unsigned FP_LEN     = 88,
   parameter int unsigned SYNC_LEN   = 44,
   parameter int unsigned BP_LEN     = 148
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 advance_i,
   output logic [BUS_WIDTH-1:0] count_o,
   output logic                 wrap_o,
   output region_e              region_o
);

   localparam int unsigned TOTAL = axis_total(ACTIVE_LEN, FP_LEN, SYNC_LEN, BP_LEN);
   localparam logic [BUS_WIDTH-1:0] LAST       = BUS_WIDTH'(TOTAL - 1);
   localparam logic [BUS_WIDTH-1:0] FP_START   = BUS_WIDTH'(ACTIVE_LEN);
   localparam logic [BUS_WIDTH-1:0] SYNC_START = BUS_WIDTH'(ACTIVE_LEN + FP_LEN);
   localparam logic [BUS_WIDTH-1:0] BP_START   = BUS_WIDTH'(ACTIVE_LEN + FP_LEN + SYNC_LEN);

   if (64'(TOTAL) >= (64'd1 << BUS_WIDTH)) begin : g_width_check
      $error("timing_axis_counter: axis total %0d does not fit in %0d bits", TOTAL, BUS_WIDTH);
   end

   logic [BUS_WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      wrap_o  = advance_i && (count_q == LAST);
      if (advance_i) begin
         count_d = wrap_o ? '0 : count_q + BUS_WIDTH'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   always_comb begin
      if (count_q < FP_START) begin
         region_o = ACTIVE;
      end else if (count_q < SYNC_START) begin
         region_o = FRONT_PORCH;
      end else if (count_q < BP_START) begin
         region_o = SYNC;
      end else begin
         region_o = BACK_PORCH;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: registered sync/de/coordinates/pulses from the pre-increment position.
// Optional frame counter output enabled by defining VTG_FRAME_COUNT_EN.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int unsigned BUS_WIDTH = 12,
   parameter int unsigned H_ACTIVE  = 1920,
   parameter int unsigned H_FP      = 88,
   parameter int unsigned H_SYNC    = 44,
   parameter int unsigned H_BP      = 148,
   parameter int unsigned V_ACTIVE  = 1080,
   parameter int unsigned V_FP      = 4,
   parameter int unsigned V_SYNC    = 5,
   parameter int unsigned V_BP      = 36,
   parameter logic        H_POL     = 1'b1,
   parameter logic        V_POL     = 1'b1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 enable,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 de,
   output logic [BUS_WIDTH-1:0] x,
   output logic [BUS_WIDTH-1:0] y,
   output logic                 line_start,
`ifdef VTG_FRAME_COUNT_EN
   output logic                 frame_start,
   output logic [15:0]          frame_count
`else
   output logic                 frame_start
`endif
);

   logic [BUS_WIDTH-1:0] hc, vc;
   logic                 h_wrap, v_wrap;
   region_e              h_region, v_region;

   timing_axis_counter #(
      .BUS_WIDTH (BUS_WIDTH),
      .ACTIVE_LEN(H_ACTIVE),
      .FP_LEN    (H_FP),
      .SYNC_LEN  (H_SYNC),
      .BP_LEN    (H_BP)
   ) u_h_axis (
      .clk_i    (clock),
      .rst_ni   (reset_n),
      .advance_i(enable),
      .count_o  (hc),
      .wrap_o   (h_wrap),
      .region_o (h_region)
   );

   // Vertical axis steps only on horizontal wrap, so vsync edges land on hc=0.
   timing_axis_counter #(
      .BUS_WIDTH (BUS_WIDTH),
      .ACTIVE_LEN(V_ACTIVE),
      .FP_LEN    (V_FP),
      .SYNC_LEN  (V_SYNC),
      .BP_LEN    (V_BP)
   ) u_v_axis (
      .clk_i    (clock),
      .rst_ni   (reset_n),
      .advance_i(h_wrap),
      .count_o  (vc),
      .wrap_o   (v_wrap),
      .region_o (v_region)
   );

   logic                 hsync_q, hsync_d;
   logic                 vsync_q, vsync_d;
   logic                 de_q, de_d;
   logic [BUS_WIDTH-1:0] x_q, x_d;
   logic [BUS_WIDTH-1:0] y_q, y_d;
   logic                 line_start_q, line_start_d;
   logic                 frame_start_q, frame_start_d;

   always_comb begin
      hsync_d       = hsync_q;
      vsync_d       = vsync_q;
      de_d          = de_q;
      x_d           = x_q;
      y_d           = y_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
      if (enable) begin
         hsync_d       = (h_region == SYNC) ? H_POL : ~H_POL;
         vsync_d       = (v_region == SYNC) ? V_POL : ~V_POL;
         de_d          = (h_region == ACTIVE) && (v_region == ACTIVE);
         line_start_d  = (hc == '0);
         frame_start_d = (hc == '0) && (vc == '0);
         if (de_d) begin
            x_d = hc;
            y_d = vc;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hsync_q       <= ~H_POL;
         vsync_q       <= ~V_POL;
         de_q          <= 1'b0;
         x_q           <= '0;
         y_q           <= '0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         de_q          <= de_d;
         x_q           <= x_d;
         y_q           <= y_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign de          = de_q;
   assign x           = x_q;
   assign y           = y_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;

`ifdef VTG_FRAME_COUNT_EN
   logic [15:0] frame_count_q, frame_count_d;

   always_comb begin
      frame_count_d = frame_count_q;
      if (frame_start_d) begin
         frame_count_d = frame_count_q + 16'd1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         frame_count_q <= '0;
      end else begin
         frame_count_q <= frame_count_d;
      end
   end

   assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench: raster-position model feeds a queue, monitor compares two polarity variants.
module tb_video_timing_gen;

   localparam int BW = 12;
   localparam int HA = 8, HF = 2, HS = 3, HB = 2;
   localparam int VA = 4, VF = 1, VS = 2, VB = 1;
   localparam int HT = HA + HF + HS + HB;
   localparam int VT = VA + VF + VS + VB;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   logic enable = 1'b0;

   logic          hs0, vs0, de0, ls0, fs0, hs1, vs1, de1, ls1, fs1;
   logic [BW-1:0] x0, y0, x1, y1;
`ifdef VTG_FRAME_COUNT_EN
   logic [15:0]   fc0, fc1;
`endif

   always #5 clock = ~clock;

   video_timing_gen #(
      .BUS_WIDTH(BW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .H_POL(1'b1), .V_POL(1'b1)
   ) dut_pos (
      .clock(clock), .reset_n(reset_n), .enable(enable),
      .hsync(hs0), .vsync(vs0), .de(de0), .x(x0), .y(y0),
      .line_start(ls0),
`ifdef VTG_FRAME_COUNT_EN
      .frame_start(fs0), .frame_count(fc0)
`else
      .frame_start(fs0)
`endif
   );

   video_timing_gen #(
      .BUS_WIDTH(BW), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .H_POL(1'b0), .V_POL(1'b0)
   ) dut_neg (
      .clock(clock), .reset_n(reset_n), .enable(enable),
      .hsync(hs1), .vsync(vs1), .de(de1), .x(x1), .y(y1),
      .line_start(ls1),
`ifdef VTG_FRAME_COUNT_EN
      .frame_start(fs1), .frame_count(fc1)
`else
      .frame_start(fs1)
`endif
   );

   // hs/vs record "inside sync region", independent of polarity.
   typedef struct {
      bit hs, vs, de, ls, fs, win;
      int x, y, fc;
   } exp_t;

   exp_t q[$];
   exp_t cur;
   int   pos;
   int   n_vec = 0;
   int   n_err = 0;
   int   de_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0, ls_cnt = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      pos = 0;
      cur = '{default: 0};
   endtask

   task automatic step(input bit en, input bit rst, input bit win);
      int hc, vc;
      @(negedge clock);
      enable  = en;
      reset_n = !rst;
      if (rst) begin
         model_reset();
      end else if (en) begin
         hc = pos % HT;
         vc = pos / HT;
         cur.hs = (hc >= HA + HF) && (hc < HA + HF + HS);
         cur.vs = (vc >= VA + VF) && (vc < VA + VF + VS);
         cur.de = (hc < HA) && (vc < VA);
         cur.ls = (hc == 0);
         cur.fs = (pos == 0);
         if (cur.de) begin
            cur.x = hc;
            cur.y = vc;
         end
         if (cur.fs) cur.fc = (cur.fc + 1) % 65536;
         pos = (pos + 1) % (HT * VT);
      end else begin
         cur.ls = 0;
         cur.fs = 0;
      end
      cur.win = win;
      q.push_back(cur);
   endtask

   // Asserts reset between clock edges and checks outputs change without waiting for a clock.
   task automatic async_reset();
      @(negedge clock);
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("async_hsync_pos", int'(hs0), 0);
      chk("async_vsync_pos", int'(vs0), 0);
      chk("async_hsync_neg", int'(hs1), 1);
      chk("async_vsync_neg", int'(vs1), 1);
      chk("async_de", int'(de0), 0);
      chk("async_x", int'(x0), 0);
      chk("async_y", int'(y0), 0);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("hsync_pos", int'(hs0), int'(e.hs));
            chk("vsync_pos", int'(vs0), int'(e.vs));
            chk("hsync_neg", int'(hs1), int'(!e.hs));
            chk("vsync_neg", int'(vs1), int'(!e.vs));
            chk("de_pos", int'(de0), int'(e.de));
            chk("de_neg", int'(de1), int'(e.de));
            chk("x_pos", int'(x0), e.x);
            chk("y_pos", int'(y0), e.y);
            chk("x_neg", int'(x1), e.x);
            chk("y_neg", int'(y1), e.y);
            chk("line_start", int'(ls0), int'(e.ls));
            chk("frame_start", int'(fs0), int'(e.fs));
            chk("line_start_neg", int'(ls1), int'(e.ls));
            chk("frame_start_neg", int'(fs1), int'(e.fs));
`ifdef VTG_FRAME_COUNT_EN
            chk("frame_count", int'(fc0), e.fc);
            chk("frame_count_neg", int'(fc1), e.fc);
`endif
            if (e.win) begin
               de_cnt += int'(de0);
               hs_cnt += int'(hs0);
               vs_cnt += int'(vs0);
               fs_cnt += int'(fs0);
               ls_cnt += int'(ls0);
            end
         end
      end
   end

   initial begin : driver
      int guard;
      model_reset();
      repeat (2) step(1'b0, 1'b1, 1'b0);

      // One full frame with enable held high, aggregated region counts.
      repeat (HT * VT) step(1'b1, 1'b0, 1'b1);

      // Pause with (7,3) as the next position, then resume.
      repeat (3) step(1'b1, 1'b1, 1'b0);
      repeat (3 * HT + 7) step(1'b1, 1'b0, 1'b0);
      repeat (5) step(1'b0, 1'b0, 1'b0);
      repeat (2) step(1'b1, 1'b0, 1'b0);

      // Mid-frame reset while vsync is asserted.
      guard = 0;
      while (!cur.vs && guard < 4 * HT * VT) begin
         step(1'b1, 1'b0, 1'b0);
         guard++;
      end
      chk("reach_vsync_region", int'(cur.vs), 1);
      repeat (4) step(1'b1, 1'b0, 1'b0);
      async_reset();
      repeat (2) step(1'b1, 1'b1, 1'b0);
      repeat (3 * HT * VT + 5) step(1'b1, 1'b0, 1'b0);

      // Randomized enable with occasional resets.
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 399) == 0) begin
            repeat ($urandom_range(1, 3)) step(1'($urandom_range(0, 1)), 1'b1, 1'b0);
         end else begin
            step(1'($urandom_range(0, 7) != 0), 1'b0, 1'b0);
         end
      end

      repeat (3) @(posedge clock);
      #2;
      chk("queue_drained", q.size(), 0);
      chk("frame_de_cycles", de_cnt, HA * VA);
      chk("frame_hsync_cycles", hs_cnt, HS * VT);
      chk("frame_vsync_cycles", vs_cnt, VS * HT);
      chk("frame_start_pulses", fs_cnt, 1);
      chk("line_start_pulses", ls_cnt, VT);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised successor to the single-counter horizontal sync generator.
- Generates complete raster timing: horizontal and vertical counters, front porch, sync and back porch regions, programmable sync polarity, data-enable, and pixel coordinates.
- Sits between the pixel clock domain and the HDMI/overlay pipeline.
- Overlay blocks consume x/y/de; the TMDS encoder consumes hsync/vsync/de.

Parameters:
- BUS_WIDTH, 12, width of all counters and coordinate outputs.
- H_ACTIVE, 1920, active pixels per line.
- H_FP, 88, horizontal front porch in pixels.
- H_SYNC, 44, horizontal sync width in pixels.
- H_BP, 148, horizontal back porch in pixels.
- V_ACTIVE, 1080, active lines per frame.
- V_FP, 4, vertical front porch in lines.
- V_SYNC, 5, vertical sync width in lines.
- V_BP, 36, vertical back porch in lines.
- H_POL, 1, hsync active level (1 = active-high).
- V_POL, 1, vsync active level (1 = active-high).

Ports:
- clock  input  1  pixel clock; all logic on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- enable  input  1  advance raster when high; hold when low.
- hsync  output  1  horizontal sync at H_POL level during the sync region.
- vsync  output  1  vertical sync at V_POL level during the sync region.
- de  output  1  high when the position is inside the active region.
- x  output  BUS_WIDTH  current column; valid when de=1.
- y  output  BUS_WIDTH  current line; valid when de=1.
- line_start  output  1  one-cycle pulse at hc=0.
- frame_start  output  1  one-cycle pulse at hc=0, vc=0.

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Both must be below 2^BUS_WIDTH; enforced by an elaboration-time check.
- Internal counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1).
- Horizontal region order: active [0, H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. Vertical regions use the same order.
- All outputs are registered and decoded from the pre-increment (hc, vc) of the same edge. Output latency is 1 cycle from counter position.
- Counter advance (on enable=1 only):
  - hc increments.
  - At hc = H_TOTAL-1, hc wraps to 0 and vc increments.
  - At vc = V_TOTAL-1 with hc = H_TOTAL-1, both wrap to 0.
- enable=0: counters and all outputs hold their values, except line_start and frame_start, which are forced to 0.
- hsync: H_POL when hc is in the horizontal sync region, else ~H_POL. vsync uses vc with V_POL.
  - vsync transitions align with hc=0 of the line, not mid-line.
- de = (hc < H_ACTIVE) && (vc < V_ACTIVE).
- x = hc and y = vc when de=1. When de=0, x and y hold their last active values.
- Reset (asynchronous assert, any time including mid-frame):
  - hc = vc = 0.
  - hsync = ~H_POL, vsync = ~V_POL.
  - de = 0, x = y = 0, line_start = frame_start = 0.
- First enabled edge after reset release: outputs show position (0,0): de=1, line_start=1, frame_start=1.
- Reset release has no synchroniser inside this block; the caller provides a synchronised deassertion.

Optional Feature:
- Macro: VTG_FRAME_COUNT_EN.
- Defined:
  - Adds output frame_count [15:0], reset value 0.
  - Increments on every edge where frame_start is registered high, wrapping 65535 -> 0.
  - The first frame after reset reports 1.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package video_timing_pkg holds:
  - Standard mode constants (1920x1080p60, 1280x720p60, 640x480p60) as H/V active, porch and sync tuples.
  - Region enum: ACTIVE, FRONT_PORCH, SYNC, BACK_PORCH.
- One natural sub-module, timing_axis_counter:
  - Parametrised by ACTIVE/FP/SYNC/BP.
  - Provides count, wrap strobe and region decode.
  - Instantiated twice: horizontal with advance=enable; vertical with advance = horizontal wrap.

Test Plan:
- Small mode (H 8/2/3/2 = 15, V 4/1/2/1 = 8, H_POL=V_POL=1), enable held 1 -> one frame = 120 cycles. de high for 32 cycles total. hsync high for cycles 10-12 of each line (3 cycles). vsync high for lines 5-6 (30 cycles). frame_start every 120 cycles.
- Same mode with H_POL=0, V_POL=0 -> hsync/vsync are the bitwise inverse of the previous run; de, x and y are identical.
- Toggle enable low for 5 cycles at hc=7, vc=3 -> all outputs frozen for 5 cycles, no pulses. Resume at x=7, y=3 de=1, then hc=8 with de=0 next cycle.
- Assert reset_n low mid-frame (vc=5 sync region) -> immediately vsync=0, de=0, x=y=0. After release, frame_start on the first enabled edge.
- Wrap boundary: hc=14, vc=7 -> next cycle line_start=1, frame_start=1, x=0, y=0, de=1.
- With VTG_FRAME_COUNT_EN, run 3 frames -> frame_count reads 1, 2, 3 at successive frame_starts. Preload near 65535 -> wraps to 0.
